// File: rtl/psg.sv
`default_nettype none
// ============================================================================
// psg : SN76489-compatible sound generator (3 tone + 1 noise, signed 16-bit mix)
// Rev 1.0
// ============================================================================
module psg #(
    parameter int PRESCALE = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  io_wrdata,
    input  logic        io_wren,
    output logic        sample_valid,
    output logic [15:0] sample
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]      pre_cnt;
    logic               tick;
    logic               tick_d;

    logic [1:0]         latch_ch;
    logic               latch_type;
    logic [1:0]         wr_ch;
    logic               wr_type;
    logic               noise_wr;

    logic [9:0]         tone_reg [3];
    logic [9:0]         tone_cnt [3];
    logic [2:0]         tone_ff;
    logic [2:0]         tone_out;
    logic               tone2_reload;
    logic [2:0]         noise_ctrl;
    logic [3:0]         att [4];

    logic [6:0]         noise_cnt;
    logic [6:0]         noise_reload;
    logic               noise_ff;
    logic               noise_flip;
    logic               lfsr_fb;
    logic [15:0]        lfsr;

    logic [3:0]         ch_out;
    logic signed [15:0] mix;

    function automatic logic [15:0] att_level(input logic [3:0] a);
        case (a)
            4'd0:    att_level = 16'd8191;
            4'd1:    att_level = 16'd6506;
            4'd2:    att_level = 16'd5168;
            4'd3:    att_level = 16'd4105;
            4'd4:    att_level = 16'd3261;
            4'd5:    att_level = 16'd2590;
            4'd6:    att_level = 16'd2057;
            4'd7:    att_level = 16'd1634;
            4'd8:    att_level = 16'd1298;
            4'd9:    att_level = 16'd1031;
            4'd10:   att_level = 16'd819;
            4'd11:   att_level = 16'd650;
            4'd12:   att_level = 16'd517;
            4'd13:   att_level = 16'd410;
            4'd14:   att_level = 16'd326;
            default: att_level = 16'd0;
        endcase
    endfunction

    assign tick = (pre_cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + 1'b1;
    end

    // Latch bytes carry their own channel/type; data bytes reuse the latch.
    always_comb begin
        wr_ch    = io_wrdata[7] ? io_wrdata[6:5] : latch_ch;
        wr_type  = io_wrdata[7] ? io_wrdata[4]   : latch_type;
        noise_wr = io_wren && (wr_ch == 2'd3) && !wr_type;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_ch   <= '0;
            latch_type <= 1'b0;
            noise_ctrl <= '0;
            for (int i = 0; i < 3; i++) tone_reg[i] <= '0;
            for (int i = 0; i < 4; i++) att[i] <= 4'hF;
        end else if (io_wren) begin
            if (io_wrdata[7]) begin
                latch_ch   <= io_wrdata[6:5];
                latch_type <= io_wrdata[4];
            end
            if (wr_type) begin
                for (int i = 0; i < 4; i++)
                    if (wr_ch == 2'(i)) att[i] <= io_wrdata[3:0];
            end else if (wr_ch == 2'd3) begin
                noise_ctrl <= io_wrdata[2:0];
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (wr_ch == 2'(i)) begin
                        if (io_wrdata[7]) tone_reg[i][3:0] <= io_wrdata[3:0];
                        else              tone_reg[i][9:4] <= io_wrdata[5:0];
                    end
                end
            end
        end
    end

    // Tone periods of 0 or 1 hold the output high instead of toggling.
    always_comb begin
        for (int i = 0; i < 3; i++)
            tone_out[i] = (tone_reg[i] < 10'd2) ? 1'b1 : tone_ff[i];
        tone2_reload = tick && (tone_cnt[2] == 10'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) tone_cnt[i] <= '0;
            tone_ff <= '0;
        end else if (tick) begin
            for (int i = 0; i < 3; i++) begin
                if (tone_cnt[i] == 10'd0) begin
                    tone_cnt[i] <= tone_reg[i];
                    if (tone_reg[i] > 10'd1) tone_ff[i] <= ~tone_ff[i];
                end else begin
                    tone_cnt[i] <= tone_cnt[i] - 10'd1;
                end
            end
        end
    end

    always_comb begin
        case (noise_ctrl[1:0])
            2'd0:    noise_reload = 7'd16;
            2'd1:    noise_reload = 7'd32;
            default: noise_reload = 7'd64;
        endcase
        noise_flip = tick && ((noise_ctrl[1:0] == 2'd3) ? tone2_reload
                                                        : (noise_cnt == 7'd0));
        lfsr_fb    = noise_ctrl[2] ? (lfsr[0] ^ lfsr[3]) : lfsr[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            noise_cnt <= '0;
            noise_ff  <= 1'b0;
            lfsr      <= 16'h8000;
        end else begin
            if (tick)
                noise_cnt <= (noise_cnt == 7'd0) ? noise_reload : noise_cnt - 7'd1;
            if (noise_flip)
                noise_ff <= ~noise_ff;
            if (noise_wr)
                lfsr <= 16'h8000;
            else if (noise_flip && !noise_ff)
                lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end

    assign ch_out = {lfsr[0], tone_out};

    always_comb begin
        mix = '0;
        for (int i = 0; i < 4; i++) begin
            if (ch_out[i]) mix = mix + $signed(att_level(att[i]));
            else           mix = mix - $signed(att_level(att[i]));
        end
    end

    // Sample is taken one clock after the tick so same-tick attenuation writes land.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_d       <= 1'b0;
            sample_valid <= 1'b0;
            sample       <= '0;
        end else begin
            tick_d       <= tick;
            sample_valid <= tick_d;
            if (tick_d) sample <= mix;
        end
    end
endmodule
`default_nettype wire
